// File: rtl/date_calendar_counter.sv
// Day/month/year calendar stage of the digital clock.
// Keeps a Gregorian date (with leap years) in binary registers, advances it on
// the day-rollover pulse, accepts validated date loads and presents BCD digits
// for the 7-segment decoders.
module date_calendar_counter #(
    parameter int unsigned YEAR_MIN  = 2000,
    parameter int unsigned YEAR_MAX  = 2099,
    parameter int unsigned RST_DAY   = 1,
    parameter int unsigned RST_MONTH = 1,
    parameter int unsigned RST_YEAR  = 2000
) (
    input  logic        built_in_clk,
    input  logic        glob_rst,
    input  logic        day_tick,
    input  logic        load_en,
    input  logic [4:0]  load_day,
    input  logic [3:0]  load_month,
    input  logic [13:0] load_year,
    output logic [7:0]  day_bcd,
    output logic [7:0]  month_bcd,
    output logic [15:0] year_bcd,
    output logic        new_year,
    output logic        load_err
);

    localparam logic [13:0] Y_MIN = 14'(YEAR_MIN);
    localparam logic [13:0] Y_MAX = 14'(YEAR_MAX);
    localparam logic [4:0]  R_DAY = 5'(RST_DAY);
    localparam logic [3:0]  R_MON = 4'(RST_MONTH);
    localparam logic [13:0] R_YR  = 14'(RST_YEAR);

    logic [4:0]  day;
    logic [3:0]  month;
    logic [13:0] year;

    logic [4:0]  cur_dim;
    logic [4:0]  load_dim;
    logic        load_ok;
    logic        date_bad;
    logic        month_end;

    // Double-dabble binary to 4-digit BCD.
    function automatic logic [15:0] bin2bcd(input logic [13:0] bin);
        logic [15:0] bcd;
        bcd = '0;
        for (int unsigned i = 0; i < 14; i++) begin
            for (int unsigned d = 0; d < 4; d++) begin
                if (bcd[4*d +: 4] >= 4'd5)
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
            bcd = {bcd[14:0], bin[13 - i]};
        end
        return bcd;
    endfunction

    // Leap test from the BCD digits: a century year is leap when its
    // hundreds count (10*thousands + hundreds) is a multiple of 4, and
    // 10*th + h == 2*th + h (mod 4); other years only need y % 4 == 0.
    function automatic logic is_leap(input logic [13:0] y);
        logic [15:0] bcd;
        logic [1:0]  cent_mod4;
        bcd       = bin2bcd(y);
        cent_mod4 = bcd[9:8] + {bcd[12], 1'b0};
        if (bcd[7:0] != 8'h00)
            return (y[1:0] == 2'b00);
        return (cent_mod4 == 2'b00);
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [13:0] y);
        logic [4:0] n;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: n = 5'd30;
            4'd2:                    n = is_leap(y) ? 5'd29 : 5'd28;
            default:                 n = 5'd31;
        endcase
        return n;
    endfunction

    // Month lengths, load validation and end-of-month detection.
    // An out-of-range month or a zero day is forced down the end-of-month
    // path so a corrupted date re-enters the legal range on the next tick.
    always_comb begin
        cur_dim   = days_in_month(month, year);
        load_dim  = days_in_month(load_month, load_year);
        load_ok   = (load_month >= 4'd1) && (load_month <= 4'd12) &&
                    (load_day != 5'd0) && (load_day <= load_dim) &&
                    (load_year >= Y_MIN) && (load_year <= Y_MAX);
        date_bad  = (month == 4'd0) || (month > 4'd12) || (day == 5'd0);
        month_end = date_bad || (day >= cur_dim);
    end

    // Date registers and event pulses; priority reset > load > tick.
    always_ff @(posedge built_in_clk) begin
        new_year <= 1'b0;
        load_err <= 1'b0;
        if (glob_rst) begin
            day   <= R_DAY;
            month <= R_MON;
            year  <= R_YR;
        end else if (load_en) begin
            if (load_ok) begin
                day   <= load_day;
                month <= load_month;
                year  <= load_year;
            end else begin
                load_err <= 1'b1;
            end
        end else if (day_tick) begin
            if (!month_end) begin
                day <= day + 5'd1;
            end else begin
                day <= 5'd1;
                if (month < 4'd12) begin
                    month <= month + 4'd1;
                end else begin
                    month    <= 4'd1;
                    new_year <= 1'b1;
                    year     <= ((year >= Y_MAX) || (year < Y_MIN)) ? Y_MIN : year + 14'd1;
                end
            end
        end
    end

    // BCD digits for the display decoders.
    always_comb begin
        day_bcd   = 8'(bin2bcd({9'd0, day}));
        month_bcd = 8'(bin2bcd({10'd0, month}));
        year_bcd  = bin2bcd(year);
    end

endmodule

// File: tb/tb_date_calendar_counter.sv
// Directed testbench for date_calendar_counter with a scoreboard fed by a
// behavioural calendar model, plus literal spot checks of key dates.
module tb_date_calendar_counter;

    logic        built_in_clk = 1'b0;
    logic        glob_rst     = 1'b0;
    logic        day_tick     = 1'b0;
    logic        load_en      = 1'b0;
    logic [4:0]  load_day     = '0;
    logic [3:0]  load_month   = '0;
    logic [13:0] load_year    = '0;
    logic [7:0]  day_bcd;
    logic [7:0]  month_bcd;
    logic [15:0] year_bcd;
    logic        new_year;
    logic        load_err;

    date_calendar_counter #(
        .YEAR_MIN  (2000),
        .YEAR_MAX  (2099),
        .RST_DAY   (1),
        .RST_MONTH (1),
        .RST_YEAR  (2000)
    ) dut (
        .built_in_clk (built_in_clk),
        .glob_rst     (glob_rst),
        .day_tick     (day_tick),
        .load_en      (load_en),
        .load_day     (load_day),
        .load_month   (load_month),
        .load_year    (load_year),
        .day_bcd      (day_bcd),
        .month_bcd    (month_bcd),
        .year_bcd     (year_bcd),
        .new_year     (new_year),
        .load_err     (load_err)
    );

    always #5 built_in_clk = ~built_in_clk;

    typedef struct packed {
        logic [7:0]  d;
        logic [7:0]  m;
        logic [15:0] y;
        logic        ny;
        logic        le;
    } exp_t;

    exp_t        sb[$];
    string       sb_tag[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int          m_day   = 1;
    int          m_month = 1;
    int          m_year  = 2000;

    function automatic bit leap(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int dim(input int m, input int y);
        if (m == 2) return leap(y) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic check_out();
        exp_t  e;
        string t;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            t = sb_tag.pop_front();
            cmp({t, ".day"},      {8'h00, day_bcd},   {8'h00, e.d});
            cmp({t, ".month"},    {8'h00, month_bcd}, {8'h00, e.m});
            cmp({t, ".year"},     year_bcd,           e.y);
            cmp({t, ".new_year"}, {15'd0, new_year},  {15'd0, e.ny});
            cmp({t, ".load_err"}, {15'd0, load_err},  {15'd0, e.le});
        end
    endtask

    // One clock cycle of stimulus: update the model, push expectations,
    // take the edge, then compare the DUT against the popped entry.
    task automatic step(input bit rst, input bit tick, input bit ld_en,
                        input int ld, input int lm, input int ly, input string tag);
        exp_t        e;
        logic [15:0] db;
        logic [15:0] mb;
        @(negedge built_in_clk);
        glob_rst   = rst;
        day_tick   = tick;
        load_en    = ld_en;
        load_day   = 5'(ld);
        load_month = 4'(lm);
        load_year  = 14'(ly);
        e.ny = 1'b0;
        e.le = 1'b0;
        if (rst) begin
            m_day = 1; m_month = 1; m_year = 2000;
        end else if (ld_en) begin
            if (lm >= 1 && lm <= 12 && ly >= 2000 && ly <= 2099 && ld >= 1 && ld <= dim(lm, ly)) begin
                m_day = ld; m_month = lm; m_year = ly;
            end else begin
                e.le = 1'b1;
            end
        end else if (tick) begin
            if (m_day < dim(m_month, m_year)) begin
                m_day++;
            end else begin
                m_day = 1;
                if (m_month < 12) begin
                    m_month++;
                end else begin
                    m_month = 1;
                    e.ny    = 1'b1;
                    m_year  = (m_year == 2099) ? 2000 : m_year + 1;
                end
            end
        end
        db  = to_bcd(m_day);
        mb  = to_bcd(m_month);
        e.d = db[7:0];
        e.m = mb[7:0];
        e.y = to_bcd(m_year);
        sb.push_back(e);
        sb_tag.push_back(tag);
        @(posedge built_in_clk);
        #1;
        glob_rst = 1'b0;
        day_tick = 1'b0;
        load_en  = 1'b0;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(1, 0, 0, 0, 0, 0, "reset");
        cmp("lit_reset_day",   {8'h00, day_bcd},   16'h0001);
        cmp("lit_reset_month", {8'h00, month_bcd}, 16'h0001);
        cmp("lit_reset_year",  year_bcd,           16'h2000);
        cmp("lit_reset_ny",    {15'd0, new_year},  16'h0000);
        cmp("lit_reset_le",    {15'd0, load_err},  16'h0000);

        step(0, 0, 1, 28, 2, 2001, "load_28feb2001");
        step(0, 1, 0, 0, 0, 0, "tick_feb2001");
        cmp("lit_mar2001_day",   {8'h00, day_bcd},   16'h0001);
        cmp("lit_mar2001_month", {8'h00, month_bcd}, 16'h0003);
        cmp("lit_mar2001_year",  year_bcd,           16'h2001);

        step(0, 0, 1, 28, 2, 2000, "load_28feb2000");
        step(0, 1, 0, 0, 0, 0, "tick_to_29feb");
        cmp("lit_29feb_day",   {8'h00, day_bcd},   16'h0029);
        cmp("lit_29feb_month", {8'h00, month_bcd}, 16'h0002);
        step(0, 1, 0, 0, 0, 0, "tick_to_1mar");
        cmp("lit_1mar_day",   {8'h00, day_bcd},   16'h0001);
        cmp("lit_1mar_month", {8'h00, month_bcd}, 16'h0003);

        step(0, 0, 1, 31, 12, 2099, "load_31dec2099");
        step(0, 1, 0, 0, 0, 0, "tick_year_wrap");
        cmp("lit_wrap_year", year_bcd,          16'h2000);
        cmp("lit_wrap_ny",   {15'd0, new_year}, 16'h0001);
        step(0, 0, 0, 0, 0, 0, "idle_after_wrap");
        cmp("lit_wrap_ny_drop", {15'd0, new_year}, 16'h0000);

        step(0, 0, 1, 31, 4, 2024, "load_31apr_bad");
        cmp("lit_bad_le",  {15'd0, load_err},  16'h0001);
        cmp("lit_bad_day", {8'h00, day_bcd},   16'h0001);
        step(0, 0, 0, 0, 0, 0, "idle_after_bad");
        cmp("lit_bad_le_drop", {15'd0, load_err}, 16'h0000);

        step(0, 1, 1, 30, 4, 2024, "load_with_tick");
        cmp("lit_lt_day",   {8'h00, day_bcd},   16'h0030);
        cmp("lit_lt_month", {8'h00, month_bcd}, 16'h0004);
        cmp("lit_lt_year",  year_bcd,           16'h2024);

        step(1, 1, 1, 31, 4, 2024, "rst_over_load_tick");
        cmp("lit_rst_pri_day", {8'h00, day_bcd},  16'h0001);
        cmp("lit_rst_pri_le",  {15'd0, load_err}, 16'h0000);

        step(0, 0, 1, 29, 2, 2001, "load_29feb2001_bad");
        step(0, 0, 1, 29, 2, 2096, "load_29feb2096");
        step(0, 1, 0, 0, 0, 0, "tick_29feb2096");
        step(0, 0, 1, 0, 5, 2050, "load_day0_bad");
        step(0, 0, 1, 1, 13, 2050, "load_month13_bad");
        step(0, 0, 1, 1, 0, 2050, "load_month0_bad");
        step(0, 0, 1, 1, 1, 1999, "load_year_low_bad");
        step(0, 0, 1, 1, 1, 2100, "load_year_high_bad");
        step(0, 0, 1, 1, 1, 2099, "load_year_max_ok");
        step(0, 0, 1, 30, 6, 2050, "load_30jun");
        step(0, 1, 0, 0, 0, 0, "tick_30jun");
        step(0, 0, 1, 31, 1, 2050, "load_31jan");
        step(0, 1, 0, 0, 0, 0, "tick_31jan");
        step(0, 0, 1, 30, 11, 2050, "load_30nov");
        step(0, 1, 0, 0, 0, 0, "tick_30nov");
        step(0, 0, 1, 31, 12, 2050, "load_31dec2050");
        step(0, 1, 0, 0, 0, 0, "tick_31dec2050");

        step(0, 0, 1, 1, 1, 2001, "load_1jan2001");
        for (int i = 0; i < 365; i++)
            step(0, 1, 0, 0, 0, 0, "year_run");
        cmp("lit_run_day",   {8'h00, day_bcd},   16'h0001);
        cmp("lit_run_month", {8'h00, month_bcd}, 16'h0001);
        cmp("lit_run_year",  year_bcd,           16'h2002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
